// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipeline control path: control-word bit layout,
// stage-register layouts and the EX operand forwarding encoding.
package ctrl_pkg;

  localparam int unsigned CTRL_W = 8;
  localparam int unsigned REG_W  = 5;

  localparam int unsigned CTRL_ALUOP_HI = 7;
  localparam int unsigned CTRL_ALUOP_LO = 6;
  localparam int unsigned CTRL_ALUSRC   = 5;
  localparam int unsigned CTRL_BRANCH   = 4;
  localparam int unsigned CTRL_MEMREAD  = 3;
  localparam int unsigned CTRL_MEMWRITE = 2;
  localparam int unsigned CTRL_REGWRITE = 1;
  localparam int unsigned CTRL_MEMTOREG = 0;

  // Later stages keep only the low control bits, so bit positions stay valid
  localparam int unsigned EXMEM_CTRL_W = 5;
  localparam int unsigned MEMWB_CTRL_W = 2;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 8'h00;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b10,
    FWD_MEMWB = 2'b01
  } fwd_sel_e;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
  } idex_t;

  typedef struct packed {
    logic [EXMEM_CTRL_W-1:0] ctrl;
    logic [REG_W-1:0]        rd;
  } exmem_t;

  typedef struct packed {
    logic [MEMWB_CTRL_W-1:0] ctrl;
    logic [REG_W-1:0]        rd;
  } memwb_t;

  // x0 is hard-wired zero, so it is never a forwarding source
  function automatic fwd_sel_e fwd_select(
    input logic             ex_we,
    input logic [REG_W-1:0] ex_rd,
    input logic             wb_we,
    input logic [REG_W-1:0] wb_rd,
    input logic [REG_W-1:0] rs
  );
    fwd_sel_e sel;
    sel = FWD_RF;
    if (ex_we && (ex_rd != '0) && (ex_rd == rs)) begin
      sel = FWD_EXMEM;
    end else if (wb_we && (wb_rd != '0) && (wb_rd == rs)) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// EX-stage operand forwarding selects; purely combinational.
module fwd_unit
  import ctrl_pkg::*;
(
  input  logic             exmem_regwrite,
  input  logic [REG_W-1:0] exmem_rd,
  input  logic             memwb_regwrite,
  input  logic [REG_W-1:0] memwb_rd,
  input  logic [REG_W-1:0] idex_rs1,
  input  logic [REG_W-1:0] idex_rs2,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  always_comb begin
    fwd_a = fwd_select(exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd, idex_rs1);
    fwd_b = fwd_select(exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd, idex_rs2);
  end

endmodule

// File: rtl/control_pipe.sv
// Carries decoded control through ID/EX, EX/MEM and MEM/WB, inserting a
// bubble on load-use hazards and squashing on taken branches.
module control_pipe
  import ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CTRL_W-1:0] Control_i,
  input  logic [REG_W-1:0]  rs1_i,
  input  logic [REG_W-1:0]  rs2_i,
  input  logic [REG_W-1:0]  rd_i,
  input  logic              flush_i,
  input  logic              mem_stall_i,
  output logic              stall_o,
  output logic [1:0]        ex_aluop_o,
  output logic              ex_alusrc_o,
  output logic              ex_branch_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              wb_regwrite_o,
  output logic              wb_memtoreg_o,
  output logic [REG_W-1:0]  wb_rd_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o
);

  idex_t  idex_q;
  exmem_t exmem_q;
  memwb_t memwb_q;
  logic   hz;

  always_comb begin
    hz = idex_q.ctrl[CTRL_MEMREAD] && (idex_q.rd != '0) &&
         ((idex_q.rd == rs1_i) || (idex_q.rd == rs2_i));
    // A squashed consumer needs no replay, so flush masks the front-end stall
    stall_o = hz && !flush_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else if (!mem_stall_i) begin
      if (flush_i || hz) begin
        idex_q <= {CTRL_BUBBLE, {REG_W{1'b0}}, {REG_W{1'b0}}, {REG_W{1'b0}}};
      end else begin
        idex_q <= {Control_i, rs1_i, rs2_i, rd_i};
      end
      exmem_q <= {idex_q.ctrl[EXMEM_CTRL_W-1:0], idex_q.rd};
      memwb_q <= {exmem_q.ctrl[MEMWB_CTRL_W-1:0], exmem_q.rd};
    end
  end

  always_comb begin
    ex_aluop_o    = idex_q.ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO];
    ex_alusrc_o   = idex_q.ctrl[CTRL_ALUSRC];
    ex_branch_o   = idex_q.ctrl[CTRL_BRANCH];
    mem_read_o    = exmem_q.ctrl[CTRL_MEMREAD];
    mem_write_o   = exmem_q.ctrl[CTRL_MEMWRITE];
    wb_regwrite_o = memwb_q.ctrl[CTRL_REGWRITE];
    wb_memtoreg_o = memwb_q.ctrl[CTRL_MEMTOREG];
    wb_rd_o       = memwb_q.rd;
  end

  fwd_unit u_fwd (
    .exmem_regwrite (exmem_q.ctrl[CTRL_REGWRITE]),
    .exmem_rd       (exmem_q.rd),
    .memwb_regwrite (memwb_q.ctrl[CTRL_REGWRITE]),
    .memwb_rd       (memwb_q.rd),
    .idex_rs1       (idex_q.rs1),
    .idex_rs2       (idex_q.rs2),
    .fwd_a          (fwd_a_o),
    .fwd_b          (fwd_b_o)
  );

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe with a write-back scoreboard.
module tb_control_pipe;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] Control_i;
  logic [4:0] rs1_i, rs2_i, rd_i;
  logic       flush_i, mem_stall_i;
  logic       stall_o;
  logic [1:0] ex_aluop_o;
  logic       ex_alusrc_o, ex_branch_o;
  logic       mem_read_o, mem_write_o;
  logic       wb_regwrite_o, wb_memtoreg_o;
  logic [4:0] wb_rd_o;
  logic [1:0] fwd_a_o, fwd_b_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic [4:0] rd;
  } wb_exp_t;

  wb_exp_t wb_q[$];
  logic    new_wb = 1'b0;

  control_pipe dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .Control_i     (Control_i),
    .rs1_i         (rs1_i),
    .rs2_i         (rs2_i),
    .rd_i          (rd_i),
    .flush_i       (flush_i),
    .mem_stall_i   (mem_stall_i),
    .stall_o       (stall_o),
    .ex_aluop_o    (ex_aluop_o),
    .ex_alusrc_o   (ex_alusrc_o),
    .ex_branch_o   (ex_branch_o),
    .mem_read_o    (mem_read_o),
    .mem_write_o   (mem_write_o),
    .wb_regwrite_o (wb_regwrite_o),
    .wb_memtoreg_o (wb_memtoreg_o),
    .wb_rd_o       (wb_rd_o),
    .fwd_a_o       (fwd_a_o),
    .fwd_b_o       (fwd_b_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] c, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic fl, input logic ms);
    Control_i   = c;
    rs1_i       = r1;
    rs2_i       = r2;
    rd_i        = rd;
    flush_i     = fl;
    mem_stall_i = ms;
    #1;
  endtask

  task automatic expect_wb(input logic [7:0] c, input logic [4:0] rd);
    wb_q.push_back({c[1], c[0], rd});
  endtask

  task automatic nop();
    drive(8'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  // A new MEM/WB value appears only after an edge with no reset and no freeze
  always @(posedge clk) new_wb <= !rst_i && !mem_stall_i;

  always @(negedge clk) begin
    if (new_wb && (wb_regwrite_o || wb_memtoreg_o)) begin
      if (wb_q.size() == 0) begin
        chk("sb_unexpected_wb", {3'b0, wb_rd_o}, 8'hFF);
      end else begin
        wb_exp_t e;
        e = wb_q.pop_front();
        chk("sb_wb_rd", {3'b0, wb_rd_o}, {3'b0, e.rd});
        chk("sb_wb_ctrl", {6'b0, wb_regwrite_o, wb_memtoreg_o}, {6'b0, e.regwrite, e.memtoreg});
      end
    end
  end

  initial begin
    // 1: reset with random inputs, then a basic R-type
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(8'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
      step();
    end
    chk("rst_ex",    {5'b0, ex_aluop_o, ex_alusrc_o, ex_branch_o}, 8'h00);
    chk("rst_mem",   {6'b0, mem_read_o, mem_write_o}, 8'h00);
    chk("rst_wb",    {1'b0, wb_regwrite_o, wb_memtoreg_o, wb_rd_o}, 8'h00);
    chk("rst_stall", {7'b0, stall_o}, 8'h00);
    chk("rst_fwd",   {4'b0, fwd_a_o, fwd_b_o}, 8'h00);
    rst_i = 1'b0;
    nop();
    step();

    drive(8'h92, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0); expect_wb(8'h92, 5'd5);
    step();
    chk("rtype_ex_aluop", {6'b0, ex_aluop_o}, 8'h02);
    chk("rtype_ex_bits",  {6'b0, ex_alusrc_o, ex_branch_o}, 8'h01);
    nop(); step();
    chk("rtype_mem", {6'b0, mem_read_o, mem_write_o}, 8'h00);
    step();
    chk("rtype_wb", {2'b0, wb_regwrite_o, wb_rd_o}, 8'h25);

    // 2: load-use hazard costs one bubble, then MEM/WB forwarding
    drive(8'h2B, 5'd1, 5'd0, 5'd6, 1'b0, 1'b0); expect_wb(8'h2B, 5'd6);
    step();
    drive(8'h82, 5'd6, 5'd7, 5'd8, 1'b0, 1'b0);
    chk("lu_stall", {7'b0, stall_o}, 8'h01);
    step();
    chk("lu_bubble",   {5'b0, ex_aluop_o, ex_alusrc_o, ex_branch_o}, 8'h00);
    chk("lu_memread",  {7'b0, mem_read_o}, 8'h01);
    chk("lu_stall_off", {7'b0, stall_o}, 8'h00);
    expect_wb(8'h82, 5'd8);
    step();
    chk("lu_add_ex", {6'b0, ex_aluop_o}, 8'h02);
    chk("lu_fwd",    {4'b0, fwd_a_o, fwd_b_o}, 8'h04);
    nop(); step(); step(); step();

    // 3: EX/MEM forwarding, mixed sources, priority, and x0
    drive(8'h22, 5'd1, 5'd0, 5'd3, 1'b0, 1'b0); expect_wb(8'h22, 5'd3); step();
    drive(8'h82, 5'd3, 5'd3, 5'd9, 1'b0, 1'b0); expect_wb(8'h82, 5'd9); step();
    chk("fwd_exmem_both", {4'b0, fwd_a_o, fwd_b_o}, 8'h0A);
    nop(); step(); step(); step();
    drive(8'h22, 5'd1, 5'd0, 5'd3, 1'b0, 1'b0); expect_wb(8'h22, 5'd3); step();
    drive(8'h22, 5'd1, 5'd0, 5'd4, 1'b0, 1'b0); expect_wb(8'h22, 5'd4); step();
    drive(8'h82, 5'd3, 5'd4, 5'd10, 1'b0, 1'b0); expect_wb(8'h82, 5'd10); step();
    chk("fwd_mixed", {4'b0, fwd_a_o, fwd_b_o}, 8'h06);
    nop(); step(); step(); step();
    drive(8'h22, 5'd1, 5'd0, 5'd4, 1'b0, 1'b0); expect_wb(8'h22, 5'd4); step();
    drive(8'h22, 5'd1, 5'd0, 5'd4, 1'b0, 1'b0); expect_wb(8'h22, 5'd4); step();
    drive(8'h82, 5'd4, 5'd0, 5'd11, 1'b0, 1'b0); expect_wb(8'h82, 5'd11); step();
    chk("fwd_priority", {4'b0, fwd_a_o, fwd_b_o}, 8'h08);
    nop(); step(); step(); step();
    drive(8'h22, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0); expect_wb(8'h22, 5'd0); step();
    drive(8'h82, 5'd0, 5'd0, 5'd12, 1'b0, 1'b0); expect_wb(8'h82, 5'd12); step();
    chk("fwd_x0", {4'b0, fwd_a_o, fwd_b_o}, 8'h00);
    nop(); step(); step(); step();

    // 4: store goes through unflushed, is squashed when flushed
    drive(8'h24, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0); step();
    nop(); step();
    chk("sd_memwrite", {7'b0, mem_write_o}, 8'h01);
    drive(8'h24, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0); step();
    chk("flush_ex", {5'b0, ex_aluop_o, ex_alusrc_o, ex_branch_o}, 8'h00);
    nop(); step();
    chk("flush_memwrite", {7'b0, mem_write_o}, 8'h00);
    drive(8'h2B, 5'd1, 5'd0, 5'd10, 1'b0, 1'b0); expect_wb(8'h2B, 5'd10); step();
    drive(8'h82, 5'd10, 5'd0, 5'd13, 1'b1, 1'b0);
    chk("flush_hz_stall", {7'b0, stall_o}, 8'h00);
    step();
    chk("flush_hz_bubble", {5'b0, ex_aluop_o, ex_alusrc_o, ex_branch_o}, 8'h00);
    nop(); step(); step(); step();

    // 5: memory stall freezes every stage
    drive(8'h22, 5'd1, 5'd0, 5'd12, 1'b0, 1'b0); expect_wb(8'h22, 5'd12); step();
    drive(8'h2B, 5'd1, 5'd0, 5'd11, 1'b0, 1'b0); expect_wb(8'h2B, 5'd11); step();
    nop(); step();
    chk("ms_pre_memread", {7'b0, mem_read_o}, 8'h01);
    chk("ms_pre_wb", {1'b0, wb_regwrite_o, wb_memtoreg_o, wb_rd_o}, 8'h4C);
    for (int i = 0; i < 3; i++) begin
      drive(8'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      step();
      chk("ms_memread", {7'b0, mem_read_o}, 8'h01);
      chk("ms_wb_frozen", {1'b0, wb_regwrite_o, wb_memtoreg_o, wb_rd_o}, 8'h4C);
    end
    nop(); step();
    chk("ms_post_memread", {7'b0, mem_read_o}, 8'h00);
    chk("ms_post_wb", {1'b0, wb_regwrite_o, wb_memtoreg_o, wb_rd_o}, 8'h6B);
    step(); step();

    // 6: memory stall with hazard holds, then reset mid-stall
    drive(8'h2B, 5'd1, 5'd0, 5'd13, 1'b0, 1'b0); step();
    drive(8'h82, 5'd13, 5'd0, 5'd14, 1'b0, 1'b1);
    chk("ms_hz_stall", {7'b0, stall_o}, 8'h01);
    step();
    chk("ms_hz_hold", {7'b0, ex_alusrc_o}, 8'h01);
    chk("ms_hz_stall2", {7'b0, stall_o}, 8'h01);
    mem_stall_i = 1'b0;
    rst_i = 1'b1;
    step();
    chk("rst2_ex",    {5'b0, ex_aluop_o, ex_alusrc_o, ex_branch_o}, 8'h00);
    chk("rst2_mem",   {6'b0, mem_read_o, mem_write_o}, 8'h00);
    chk("rst2_wb",    {1'b0, wb_regwrite_o, wb_memtoreg_o, wb_rd_o}, 8'h00);
    chk("rst2_stall", {7'b0, stall_o}, 8'h00);
    rst_i = 1'b0;
    nop(); step(); step(); step(); step();
    chk("sb_drained", 8'(wb_q.size()), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
